// File: rtl/max_stream_selector.sv
// Streaming frame reducer: returns the max operand, its index and the frame length.
// Optional minimum tracker enabled by defining MAX_STREAM_MIN_TRACK_EN.
module max_stream_selector #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_cnt
`ifdef MAX_STREAM_MIN_TRACK_EN
    ,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_min_idx
`endif
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [WIDTH-1:0] max_q;
    logic [IDX_W-1:0] idx_q;
    logic             take;
    logic             first;
    logic             close;
    logic             max_upd;
    logic [WIDTH-1:0] max_nxt;
    logic [IDX_W-1:0] idx_nxt;

    // Handshake outputs decode the registered state only.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    assign take  = in_valid && in_ready;
    assign first = (cnt == '0);
    assign close = take && (in_last || (cnt == LAST_POS));

    // The first operand loads unconditionally; later ones win only on strictly greater.
    assign max_upd = first || (in_data > max_q);
    assign max_nxt = max_upd ? in_data : max_q;
    assign idx_nxt = max_upd ? cnt : idx_q;

`ifdef MAX_STREAM_MIN_TRACK_EN
    logic [WIDTH-1:0] min_q;
    logic [IDX_W-1:0] min_idx_q;
    logic             min_upd;
    logic [WIDTH-1:0] min_nxt;
    logic [IDX_W-1:0] min_idx_nxt;

    assign min_upd     = first || (in_data < min_q);
    assign min_nxt     = min_upd ? in_data : min_q;
    assign min_idx_nxt = min_upd ? cnt : min_idx_q;

    // Minimum tracker mirrors the max path, loading results on the closing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q       <= '0;
            min_idx_q   <= '0;
            out_min     <= '0;
            out_min_idx <= '0;
        end else if (take) begin
            min_q     <= min_nxt;
            min_idx_q <= min_idx_nxt;
            if (close) begin
                out_min     <= min_nxt;
                out_min_idx <= min_idx_nxt;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: close a frame into HOLD, release on the result handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (close) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Accumulate per operand and latch the frame result on the closing transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            out_max <= '0;
            out_idx <= '0;
            out_cnt <= '0;
        end else if (take) begin
            max_q <= max_nxt;
            idx_q <= idx_nxt;
            if (close) begin
                cnt     <= '0;
                out_max <= max_nxt;
                out_idx <= idx_nxt;
                out_cnt <= {1'b0, cnt} + (IDX_W + 1)'(1);
            end else begin
                cnt <= cnt + IDX_W'(1);
            end
        end
    end

endmodule
